// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants and types for the CPU-side memory/I-O responder.
//   IO_BASE_HI      cpu_a[17:16] value that selects the I/O window (0x30000).
//   OFF_*           I/O register offsets, decoded from cpu_a[2:0].
//   sel_e           registered read-source select (RAM or I/O).
package mem_io_pkg;

  localparam logic [1:0] IO_BASE_HI = 2'b11;

  localparam logic [2:0] OFF_UART  = 3'd0;
  localparam logic [2:0] OFF_CLK   = 3'd4;
  localparam logic [2:0] OFF_SNAP1 = 3'd5;
  localparam logic [2:0] OFF_SNAP2 = 3'd6;
  localparam logic [2:0] OFF_SNAP3 = 3'd7;

  typedef enum logic {
    SEL_RAM,
    SEL_IO
  } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk_in, rst_in  clock, asynchronous active-high reset (empties the FIFO).
//   push, din       write request/data; ignored when full unless a pop frees the slot.
//   pop, dout       read request/head data; pop ignored when empty, dout is 0 when empty.
//   empty, full     status flags.
//   count           number of stored entries (0..DEPTH).
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; dout is masked while empty.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: responder for the CPU byte memory bus.
//   clk_in, rst_in, rdy_in          clock, async active-high reset, global CPU ready.
//   cpu_a, cpu_wdata, cpu_wr        CPU request; cpu_rdata returned one cycle later.
//   io_buffer_full                  TX FIFO is within FULL_MARGIN slots of full.
//   ram_a, ram_wdata, ram_we        external 128KB RAM (combinational from the request).
//   ram_rdata                       RAM read data, one cycle after the address.
//   tx_data, tx_valid, tx_ready     UART transmit stream (from TX FIFO).
//   rx_data, rx_valid, rx_ready     UART receive stream (into RX FIFO).
//   program_stop, tx_overflow       sticky status flags.
// I/O window at cpu_a[17:16]==2'b11, register offset cpu_a[2:0]:
//   0 rd: pop RX byte (0 when empty)   0 wr: push TX byte (0x00 filtered)
//   4 rd: counter[7:0] + snapshot       4 wr: set program_stop, push 0x00
//   5..7 rd: snapshot bytes 1..3
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1;
  localparam logic [TXCW-1:0] TX_FULL_TH = TXCW'(TX_DEPTH - FULL_MARGIN);

  // Registers
  sel_e        r_sel;
  logic [7:0]  r_io_rdata;
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  logic        r_stop;
  logic        r_ovf;

  // Decode
  logic        w_io_sel;
  logic [2:0]  w_off;
  logic        w_rd_io;
  logic        w_wr_io;
  logic [7:0]  w_io_rdata;

  // FIFO wiring
  logic            w_tx_push_req;
  logic            w_tx_pop;
  logic            w_tx_drop;
  logic [7:0]      w_tx_din;
  logic [7:0]      w_tx_dout;
  logic            w_tx_empty;
  logic            w_tx_full;
  logic [TXCW-1:0] w_tx_count;

  logic            w_rx_push;
  logic            w_rx_pop;
  logic [7:0]      w_rx_dout;
  logic            w_rx_empty;
  logic            w_rx_full;
  logic [RXCW-1:0] w_rx_count;

  logic            w_unused;

  assign w_io_sel = (cpu_a[17:16] == IO_BASE_HI);
  assign w_off    = cpu_a[2:0];
  assign w_rd_io  = rdy_in & w_io_sel & ~cpu_wr;
  assign w_wr_io  = rdy_in & w_io_sel & cpu_wr;

  // RAM path is purely combinational; the RAM registers the address itself.
  assign ram_a     = cpu_a[16:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_wr & rdy_in & ~w_io_sel;

  // TX push: UART data (non-zero only) or the stop marker, blocked once stopped.
  assign w_tx_push_req = w_wr_io & ~r_stop &
                         (((w_off == OFF_UART) & (cpu_wdata != 8'h00)) | (w_off == OFF_CLK));
  assign w_tx_din      = (w_off == OFF_CLK) ? 8'h00 : cpu_wdata;
  assign w_tx_pop      = ~w_tx_empty & tx_ready;
  assign w_tx_drop     = w_tx_push_req & w_tx_full & ~w_tx_pop;

  // The FIFO ignores a pop while empty, so reads of an empty RX return 0 with no pop.
  assign w_rx_pop  = w_rd_io & (w_off == OFF_UART);
  assign w_rx_push = rx_valid & ~w_rx_full;

  assign tx_valid       = ~w_tx_empty;
  assign tx_data        = w_tx_dout;
  assign rx_ready       = ~w_rx_full;
  assign io_buffer_full = (w_tx_count >= TX_FULL_TH);
  assign program_stop   = r_stop;
  assign tx_overflow    = r_ovf;

  assign cpu_rdata = (r_sel == SEL_RAM) ? ram_rdata : r_io_rdata;

  always_comb begin
    w_io_rdata = 8'h00;
    if (w_io_sel && !cpu_wr) begin
      case (w_off)
        OFF_UART:  w_io_rdata = w_rx_dout;
        OFF_CLK:   w_io_rdata = r_cnt[7:0];
        OFF_SNAP1: w_io_rdata = r_snap[15:8];
        OFF_SNAP2: w_io_rdata = r_snap[23:16];
        OFF_SNAP3: w_io_rdata = r_snap[31:24];
        default:   w_io_rdata = 8'h00;
      endcase
    end
  end

  // Read-return pipeline; holds while the CPU is stalled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel      <= SEL_RAM;
      r_io_rdata <= 8'h00;
    end else if (rdy_in) begin
      r_sel      <= w_io_sel ? SEL_IO : SEL_RAM;
      r_io_rdata <= w_io_rdata;
    end
  end

  // Cycle counter and its snapshot; reading byte 0 freezes all four bytes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= 32'h0;
      r_snap <= 32'h0;
    end else begin
      if (rdy_in) r_cnt <= r_cnt + 32'h1;
      if (w_rd_io && (w_off == OFF_CLK)) r_snap <= r_cnt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_stop <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_io && (w_off == OFF_CLK)) r_stop <= 1'b1;
      if (w_tx_drop) r_ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_tx_push_req),
    .pop    (w_tx_pop),
    .din    (w_tx_din),
    .dout   (w_tx_dout),
    .empty  (w_tx_empty),
    .full   (w_tx_full),
    .count  (w_tx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_rx_push),
    .pop    (w_rx_pop),
    .din    (rx_data),
    .dout   (w_rx_dout),
    .empty  (w_rx_empty),
    .full   (w_rx_full),
    .count  (w_rx_count)
  );

  assign w_unused = ^{cpu_a[31:18], w_rx_count, w_rx_empty};

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: directed bench for mem_io_ctrl with an abstract queue-based model
// checked every cycle, plus literal expectations from the test plan.
module tb_mem_io_ctrl;

  localparam int TXD = 16;
  localparam int RXD = 8;
  localparam int MARGIN = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  mem_io_ctrl #(
    .TX_DEPTH    (TXD),
    .RX_DEPTH    (RXD),
    .FULL_MARGIN (MARGIN)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .cpu_a          (cpu_a),
    .cpu_wdata      (cpu_wdata),
    .cpu_wr         (cpu_wr),
    .cpu_rdata      (cpu_rdata),
    .io_buffer_full (io_buffer_full),
    .ram_a          (ram_a),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_rdata      (ram_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External synchronous RAM.
  bit [7:0] env_mem [0:131071];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rdata <= 8'h00;
    end else begin
      if (ram_we) env_mem[ram_a] <= ram_wdata;
      ram_rdata <= env_mem[ram_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  bit   [7:0]  m_ram [0:131071];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  bit          m_stop;
  bit          m_ovf;
  bit          m_exp_valid;
  bit          m_exp_ram;
  logic [7:0]  m_exp;
  bit          mv_io;
  logic [2:0]  mv_off;
  bit          mv_rxok;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_tx.delete();
        m_rx.delete();
        m_cnt = 0;
        m_snap = 0;
        m_stop = 0;
        m_ovf = 0;
        m_exp_valid = 0;
        m_exp_ram = 1;
        m_exp = 0;
      end else begin
        mv_io   = (cpu_a[17:16] == 2'b11);
        mv_off  = cpu_a[2:0];
        mv_rxok = rx_valid && (m_rx.size() < RXD);
        if (tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
        if (rdy) begin
          if (!cpu_wr) begin
            m_exp_valid = 1;
            m_exp_ram   = !mv_io;
            if (!mv_io) begin
              m_exp = m_ram[cpu_a[16:0]];
            end else begin
              case (mv_off)
                3'd0: m_exp = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
                3'd4: begin m_exp = m_cnt[7:0]; m_snap = m_cnt; end
                3'd5: m_exp = m_snap[15:8];
                3'd6: m_exp = m_snap[23:16];
                3'd7: m_exp = m_snap[31:24];
                default: m_exp = 8'h00;
              endcase
            end
          end else begin
            m_exp_valid = 0;
            if (!mv_io) begin
              m_ram[cpu_a[16:0]] = cpu_wdata;
            end else if (!m_stop && ((mv_off == 3'd0 && cpu_wdata != 8'h00) || mv_off == 3'd4)) begin
              if (m_tx.size() < TXD) m_tx.push_back(mv_off == 3'd4 ? 8'h00 : cpu_wdata);
              else m_ovf = 1;
            end
            if (mv_io && mv_off == 3'd4) m_stop = 1;
          end
          m_cnt = m_cnt + 1;
        end else if (m_exp_ram) begin
          m_exp_valid = 0;
        end
        if (mv_rxok) m_rx.push_back(rx_data);
      end
    end
  end

  // Per-cycle compare against the model, plus TX byte log and RAM write count.
  logic [7:0] tx_log[$];
  int         n_we = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("tx_valid", tx_valid, m_tx.size() > 0);
        if (m_tx.size() > 0) chk("tx_data", tx_data, m_tx[0]);
        chk("io_buffer_full", io_buffer_full, m_tx.size() >= TXD - MARGIN);
        chk("rx_ready", rx_ready, m_rx.size() < RXD);
        chk("program_stop", program_stop, m_stop);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("ram_we", ram_we, cpu_wr && rdy && (cpu_a[17:16] != 2'b11));
        if (m_exp_valid) chk("cpu_rdata", cpu_rdata, m_exp);
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (ram_we) n_we++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_wr = 1'b0;
    cpu_a = 32'h0;
    cpu_wdata = 8'h00;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a;
    cpu_wdata = d;
    cpu_wr = 1'b1;
    tick();
    idle();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [7:0] d);
    cpu_a = a;
    cpu_wr = 1'b0;
    tick();
    d = cpu_rdata;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  logic [7:0] b0, b1, b2, b3;
  int         we0;

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst cpu_rdata", cpu_rdata, 8'h00);
    chk("rst io_buffer_full", io_buffer_full, 1'b0);
    chk("rst ram_we", ram_we, 1'b0);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst rx_ready", rx_ready, 1'b1);
    chk("rst program_stop", program_stop, 1'b0);
    chk("rst tx_overflow", tx_overflow, 1'b0);
    rst = 1'b0;
    tick();

    // RAM write then read.
    we0 = n_we;
    cpu_a = 32'h0000_0100; cpu_wdata = 8'h5A; cpu_wr = 1'b1;
    #1 chk("ram write we", ram_we, 1'b1);
    tick();
    cpu_a = 32'h0000_0100; cpu_wr = 1'b0;
    #1 chk("ram read we", ram_we, 1'b0);
    tick();
    chk("ram readback", cpu_rdata, 8'h5A);
    idle();
    tick();
    chk("ram_we pulses", n_we - we0, 1);

    // TX with zero filter.
    tx_ready = 1'b1;
    tx_log.delete();
    bus_wr(32'h0003_0000, 8'h41);
    bus_wr(32'h0003_0000, 8'h00);
    bus_wr(32'h0003_0000, 8'h42);
    repeat (4) tick();
    chk("tx filt count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("tx filt b0", tx_log[0], 8'h41);
      chk("tx filt b1", tx_log[1], 8'h42);
    end

    // TX fill, nearly-full flag, overflow, drain.
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      bus_wr(32'h0003_0000, 8'(i));
      chk("io_buffer_full fill", io_buffer_full, i >= 12);
    end
    bus_wr(32'h0003_0000, 8'h99);
    chk("overflow set", tx_overflow, 1'b1);
    chk("overflow head", tx_data, 8'h01);
    tx_log.delete();
    tx_ready = 1'b1;
    repeat (20) tick();
    chk("drain count", tx_log.size(), 16);
    for (int i = 0; i < 16 && i < tx_log.size(); i++) chk("drain order", tx_log[i], 32'(i + 1));

    // RX FIFO reads, including a stalled cycle.
    rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000, b0);
    chk("rx first", b0, 8'h11);
    rdy = 1'b0;
    cpu_a = 32'h0003_0000;
    tick();
    chk("rx stall hold", cpu_rdata, 8'h11);
    rdy = 1'b1;
    bus_rd(32'h0003_0000, b1);
    chk("rx second", b1, 8'h22);
    bus_rd(32'h0003_0000, b2);
    chk("rx empty", b2, 8'h00);

    // Counter snapshot after 300 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (300) tick();
    bus_rd(32'h0003_0004, b0);
    bus_rd(32'h0003_0005, b1);
    bus_rd(32'h0003_0006, b2);
    bus_rd(32'h0003_0007, b3);
    chk("counter snapshot", {b3, b2, b1, b0}, 32'h0000_012C);

    // Program stop, post-stop TX block, RAM still writable.
    tx_ready = 1'b0;
    bus_wr(32'h0003_0004, 8'hAB);
    chk("stop set", program_stop, 1'b1);
    chk("stop tx_valid", tx_valid, 1'b1);
    chk("stop tx_data", tx_data, 8'h00);
    tx_log.delete();
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h55);
    repeat (3) tick();
    chk("stop tx count", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("stop tx byte", tx_log[0], 8'h00);
    bus_wr(32'h0000_0200, 8'h77);
    bus_rd(32'h0000_0200, b0);
    chk("ram after stop", b0, 8'h77);

    // Asynchronous reset mid-cycle clears state.
    rx_valid = 1'b1; rx_data = 8'h33;
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst program_stop", program_stop, 1'b0);
    chk("arst tx_valid", tx_valid, 1'b0);
    chk("arst rx_ready", rx_ready, 1'b1);
    chk("arst tx_overflow", tx_overflow, 1'b0);
    chk("arst cpu_rdata", cpu_rdata, 8'h00);
    tick();
    rst = 1'b0;
    bus_rd(32'h0003_0004, b0);
    chk("arst counter", b0, 8'h00);
    bus_rd(32'h0003_0000, b1);
    chk("arst rx empty", b1, 8'h00);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Responder at the far end of the CPU byte memory bus (address, write strobe, 8-bit data each way, 1-cycle read latency).
- Decodes each CPU access to either the external 128KB byte RAM or the memory-mapped I/O window at 0x30000.
- Owns the UART TX/RX FIFOs, the free-running cycle counter, and the program-stop flag.
- Drives io_buffer_full back to the CPU.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2).
- RX_DEPTH, 8, RX FIFO entries (power of 2).
- FULL_MARGIN, 4, TX free-slot margin at which io_buffer_full asserts; covers CPU pause-register lag plus in-flight stores.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; CPU-side actions are frozen when low.
- cpu_a  input  32  CPU address; only bits 17:0 are decoded.
- cpu_wdata  input  8  store data from CPU.
- cpu_wr  input  1  1 = write, 0 = read.
- cpu_rdata  output  8  load data to CPU, valid the cycle after the request.
- io_buffer_full  output  1  TX FIFO nearly full.
- ram_a  output  17  RAM byte address.
- ram_wdata  output  8  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_rdata  input  8  RAM read data, synchronous (address registered, data next cycle).
- tx_data  output  8  UART TX byte.
- tx_valid  output  1  TX byte available.
- tx_ready  input  1  UART accepts byte.
- rx_data  input  8  UART RX byte.
- rx_valid  input  1  RX byte offered.
- rx_ready  output  1  RX FIFO not full.
- program_stop  output  1  sticky; set by a write to 0x30004.
- tx_overflow  output  1  sticky; a TX write was dropped.

Behaviour:
- Address decode:
  - cpu_a[17:16]==2'b11 selects I/O; anything else selects RAM.
  - RAM path: ram_a = cpu_a[16:0]; ram_wdata = cpu_wdata; ram_we = cpu_wr & rdy_in & RAM-select. All three are combinational.
- Read path:
  - A registered select sel_q (RAM / IO) and io_rdata_q update only when rdy_in=1.
  - cpu_rdata = sel_q==RAM ? ram_rdata : io_rdata_q. Latency is exactly 1 cycle for both RAM and I/O.
  - While rdy_in=0, sel_q and io_rdata_q hold.
- I/O offset is cpu_a[2:0]; every I/O action requires rdy_in=1.
- Offset 0, read:
  - io_rdata_q = RX FIFO head and pop it.
  - If the RX FIFO is empty, return 0x00 and do not pop.
  - Every such cycle counts as a load; the CPU presents 0x30000 only for real loads.
- Offset 0, write:
  - Push cpu_wdata into the TX FIFO.
  - A value of 0x00 is ignored.
- Offset 4, read:
  - Return counter[7:0].
  - Snapshot the full counter into snap_q in the same cycle.
- Offsets 5, 6, 7, read: return snap_q[15:8], [23:16], [31:24]. The 4 bytes are consistent if byte 4 is read first.
- Offset 4, write:
  - Set program_stop.
  - Push 0x00 into the TX FIFO; the zero filter is bypassed for this push.
- Other I/O offsets: reads return 0x00; writes are ignored.
- After program_stop is set, all further TX pushes are ignored. RAM writes still proceed.
- Cycle counter: 32-bit; increments every cycle with rdy_in=1; wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - UART pops the head when tx_valid & tx_ready; tx_valid = !empty; tx_data = head.
  - A push while full is dropped and sets tx_overflow.
  - A push and pop in the same cycle are both performed, including when full (pop frees the slot first) and when empty (pushed byte is not visible until the next cycle).
  - io_buffer_full = (tx_count >= TX_DEPTH - FULL_MARGIN), decoded from the count register.
- RX FIFO:
  - Pushes when rx_valid & rx_ready; rx_ready = !full.
  - A simultaneous CPU pop and UART push are both performed.
- UART-side FIFO activity is independent of rdy_in.
- Reset values (asynchronous, any time including mid-access; FIFOs emptied, in-flight read discarded):
  - cpu_rdata 0, io_buffer_full 0, ram_we 0, tx_valid 0, tx_data 0.
  - rx_ready 1, program_stop 0, tx_overflow 0.
  - counter 0, snap_q 0, sel_q RAM.

Decomposition:
- Package mem_io_pkg holds:
  - IO_BASE_HI = 2'b11; offsets OFF_UART = 3'd0, OFF_CLK = 3'd4.
  - Select enum {SEL_RAM, SEL_IO}.
- One sub-module, sync_fifo (params WIDTH, DEPTH):
  - Ports: push, pop, din, dout, empty, full, count.
  - Async active-high reset.
  - Instanced twice: TX and RX.

Test Plan:
- Write 0x5A to 0x00100, then read 0x00100 -> ram_we pulses once; cpu_rdata=0x5A on the cycle after the read request.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence is 0x41, 0x42 only; 0x00 never appears.
- Hold tx_ready=0 and write 16 bytes:
  - io_buffer_full rises after the 12th push.
  - A 17th write sets tx_overflow; FIFO contents are unchanged.
  - Releasing tx_ready drains 16 bytes in order.
- Reset, run 300 cycles with rdy_in=1, then read 0x30004..0x30007 on consecutive cycles -> the bytes assemble the counter value at the 0x30004 request (0x0000012C at cycle 300) despite the counter moving.
- rx pushes 0x11, 0x22; CPU reads 0x30000 three times -> 0x11, 0x22, 0x00. With rdy_in=0 during one read, nothing is popped and cpu_rdata holds.
- Write 0x30004 -> program_stop=1 and 0x00 emitted on TX. A subsequent write of 0x55 to 0x30000 produces no TX byte. Asserting rst_in mid-sequence clears program_stop, the FIFOs and the counter asynchronously.
